// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, reset vector
// default and opcode field location.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int OP_W   = OP_MSB - OP_LSB + 1;

  function automatic logic [OP_W-1:0] opcode_of(input logic [31:0] insn);
    return insn[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Combinational next-PC selection: jump, taken branch, or fall-through.
// Jump takes priority over branch; all arithmetic wraps modulo 2^32.
module inst_fetch_pc_next (
  input  logic [31:0] pc_plus4,
  input  logic        pcw,
  input  logic        pcwc,
  input  logic        cond,
  input  logic [25:0] jtarget,
  input  logic [15:0] boff,
  output logic [31:0] next_pc
);

  logic [31:0] boff_bytes;

  // Word offset sign-extended and scaled to bytes in one step.
  assign boff_bytes = {{14{boff[15]}}, boff, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (pcw) begin
      next_pc = {pc_plus4[31:28], jtarget, 2'b00};
    end else if (pcwc && cond) begin
      next_pc = pc_plus4 + boff_bytes;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests a word at pc, latches it into ir, and holds
// it until downstream consumes it, at which point the next PC is applied.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] ir,
  output logic [5:0]  op,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] pc_plus4,
  input  logic        pcw,
  input  logic        pcwc,
  input  logic        cond,
  input  logic [25:0] jtarget,
  input  logic [15:0] boff
);

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] pc_plus4_reg;
  logic        ir_valid_reg;
  logic        imem_req_reg;
  logic [31:0] next_pc;

  inst_fetch_pc_next pc_next (
    .pc_plus4 (pc_plus4_reg),
    .pcw      (pcw),
    .pcwc     (pcwc),
    .cond     (cond),
    .jtarget  (jtarget),
    .boff     (boff),
    .next_pc  (next_pc)
  );

  // imem_req is registered alongside the state so it is high exactly in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_VECTOR;
      ir_reg       <= '0;
      pc_plus4_reg <= '0;
      ir_valid_reg <= 1'b0;
      imem_req_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= FETCH;
          imem_req_reg <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            ir_reg       <= imem_data;
            pc_plus4_reg <= pc_reg + 32'd4;
            ir_valid_reg <= 1'b1;
            imem_req_reg <= 1'b0;
            state_reg    <= HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            ir_valid_reg <= 1'b0;
            pc_reg       <= next_pc;
            imem_req_reg <= 1'b1;
            state_reg    <= FETCH;
          end
        end
        default: begin
          state_reg    <= IDLE;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_reg;
  assign imem_addr = pc_reg;
  assign ir        = ir_reg;
  assign op        = opcode_of(ir_reg);
  assign ir_valid  = ir_valid_reg;
  assign pc_plus4  = pc_plus4_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: cycle-level behavioural model plus
// directed scenarios with literal expectations.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic [5:0]  op;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic [31:0] pc_plus4;
  logic        pcw = 1'b0;
  logic        pcwc = 1'b0;
  logic        cond = 1'b0;
  logic [25:0] jtarget = '0;
  logic [15:0] boff = '0;

  int checks = 0;
  int errors = 0;

  int ack_wait  = 0;
  int wait_cnt  = 0;
  logic ack_force = 1'b0;

  inst_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .ir        (ir),
    .op        (op),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .pc_plus4  (pc_plus4),
    .pcw       (pcw),
    .pcwc      (pcwc),
    .cond      (cond),
    .jtarget   (jtarget),
    .boff      (boff)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0800_0004;
    return a ^ 32'hC3A5_1E00;
  endfunction

  assign imem_data = mem_word(imem_addr);

  // Memory responder: ack after ack_wait request cycles; ack_force drives ack anytime.
  always @(negedge clk) begin
    if (imem_req) begin
      imem_ack = ack_force || (wait_cnt >= ack_wait);
      wait_cnt = imem_ack ? 0 : wait_cnt + 1;
    end else begin
      imem_ack = ack_force;
      wait_cnt = 0;
    end
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Behavioural model: "started" once the post-reset cycle has passed; when no
  // instruction is held, a fetch of m_pc is outstanding.
  logic        m_started = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ir = 32'h0;
  logic [31:0] m_pp4 = 32'h0;

  function automatic logic [31:0] model_target(input logic [31:0] pp4, input logic jmp,
                                               input logic br, input logic c,
                                               input logic [25:0] jt, input logic [15:0] bo);
    logic [31:0] off;
    off = 32'($signed(bo));
    if (jmp) return (pp4 & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
    if (br && c) return pp4 + off * 32'd4;
    return pp4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0;
      m_valid   <= 1'b0;
      m_pc      <= 32'h0;
      m_ir      <= 32'h0;
      m_pp4     <= 32'h0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (!m_valid) begin
      if (imem_ack) begin
        m_ir    <= mem_word(m_pc);
        m_pp4   <= m_pc + 32'd4;
        m_valid <= 1'b1;
      end
    end else if (ir_ready) begin
      m_valid <= 1'b0;
      m_pc    <= model_target(m_pp4, pcw, pcwc, cond, jtarget, boff);
    end
  end

  always @(negedge clk) begin
    chk1("cyc_imem_req", imem_req, m_started && !m_valid);
    chk32("cyc_imem_addr", imem_addr, m_pc);
    chk1("cyc_ir_valid", ir_valid, m_valid);
    chk32("cyc_ir", ir, m_ir);
    chk32("cyc_op", {26'd0, op}, m_ir >> 26);
    chk32("cyc_pc_plus4", pc_plus4, m_pp4);
  end

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!ir_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ir_valid) chk1({nm, "_timeout"}, ir_valid, 1'b1);
  endtask

  // Consume the held instruction with the given control inputs, then check the
  // address of the following fetch. Controls carry junk outside the handshake.
  task automatic handshake(input logic p_w, input logic p_wc, input logic c,
                           input logic [25:0] jt, input logic [15:0] bo,
                           input logic [31:0] exp_addr, input string nm);
    wait_valid(nm);
    pcw = p_w; pcwc = p_wc; cond = c; jtarget = jt; boff = bo;
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    pcw = 1'b1; pcwc = 1'b1; cond = 1'b1; jtarget = 26'h3FF_FFFF; boff = 16'h7FFF;
    chk1({nm, "_req"}, imem_req, 1'b1);
    chk32({nm, "_addr"}, imem_addr, exp_addr);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", ir_valid, 1'b0);
    chk32("rst_ir", ir, 32'h0);
    chk32("rst_pc_plus4", pc_plus4, 32'h0);
    chk32("rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Zero-wait memory, ir_ready held high: one instruction every two cycles.
    @(negedge clk);
    chk1("c1_req", imem_req, 1'b1);
    chk32("c1_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk1("c2_valid", ir_valid, 1'b1);
    chk32("c2_ir", ir, 32'h0800_0004);
    chk32("c2_op", {26'd0, op}, 32'h2);
    chk32("c2_pc_plus4", pc_plus4, 32'h4);
    @(negedge clk);
    chk32("seq_addr4", imem_addr, 32'h4);
    chk1("seq_valid_drop1", ir_valid, 1'b0);
    @(negedge clk);
    chk1("seq_valid2", ir_valid, 1'b1);
    @(negedge clk);
    chk32("seq_addr8", imem_addr, 32'h8);
    chk1("seq_valid_drop2", ir_valid, 1'b0);
    @(negedge clk);
    chk1("seq_valid3", ir_valid, 1'b1);
    chk32("seq_ir8", ir, mem_word(32'h8));
    ir_ready = 1'b0;

    handshake(1'b1, 1'b0, 1'b0, 26'h010_0003, 16'h0, 32'h0040_000C, "jmp_setup");
    wait_valid("jmp_wait");
    chk32("jmp_pp4", pc_plus4, 32'h0040_0010);
    handshake(1'b1, 1'b0, 1'b0, 26'h000_0040, 16'h0, 32'h0000_0100, "jump");

    handshake(1'b1, 1'b0, 1'b0, 26'h7, 16'h0, 32'h0000_001C, "br_setup1");
    wait_valid("br_wait");
    chk32("br_pp4", pc_plus4, 32'h0000_0020);
    handshake(1'b0, 1'b1, 1'b1, 26'h0, 16'hFFFE, 32'h0000_0018, "br_taken");
    handshake(1'b1, 1'b0, 1'b0, 26'h7, 16'h0, 32'h0000_001C, "br_setup2");
    handshake(1'b0, 1'b1, 1'b0, 26'h0, 16'hFFFE, 32'h0000_0020, "br_not_taken");
    handshake(1'b1, 1'b0, 1'b0, 26'h7, 16'h0, 32'h0000_001C, "br_setup3");
    handshake(1'b1, 1'b1, 1'b1, 26'h30, 16'hFFFE, 32'h0000_00C0, "jmp_wins");

    // Memory stall of 3 cycles, then downstream stall of 4 cycles with a stray ack.
    ack_wait = 3;
    handshake(1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0000_00C4, "stall_seq");
    for (int i = 0; i < 3; i++) begin
      chk32("mstall_addr", imem_addr, 32'h0000_00C4);
      chk1("mstall_valid", ir_valid, 1'b0);
      chk32("mstall_ir", ir, mem_word(32'h0000_00C0));
      @(negedge clk);
    end
    wait_valid("mstall_wait");
    ack_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk32("rstall_ir", ir, mem_word(32'h0000_00C4));
      chk32("rstall_pp4", pc_plus4, 32'h0000_00C8);
      chk1("rstall_valid", ir_valid, 1'b1);
      chk1("rstall_req", imem_req, 1'b0);
      @(negedge clk);
    end
    ack_force = 1'b0;
    ack_wait = 0;

    // Branch back from address 0 to the top of the address space, then wrap.
    handshake(1'b1, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0000_0000, "wrap_setup");
    handshake(1'b0, 1'b1, 1'b1, 26'h0, 16'hFFFE, 32'hFFFF_FFFC, "wrap_back");
    wait_valid("wrap_wait");
    chk32("wrap_pp4", pc_plus4, 32'h0000_0000);
    chk32("wrap_ir", ir, mem_word(32'hFFFF_FFFC));
    handshake(1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0000_0000, "wrap_seq");
    wait_valid("wrap_wait2");
    chk32("wrap_pp4b", pc_plus4, 32'h0000_0004);

    // Reset in the middle of a FETCH with an ack pending.
    ack_force = 1'b1;
    handshake(1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0000_0004, "mid_seq");
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst_req", imem_req, 1'b0);
    chk1("mid_rst_valid", ir_valid, 1'b0);
    chk32("mid_rst_addr", imem_addr, 32'h0);
    chk32("mid_rst_ir", ir, 32'h0);
    chk32("mid_rst_pp4", pc_plus4, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("refetch_req", imem_req, 1'b1);
    chk32("refetch_addr", imem_addr, 32'h0);
    chk1("refetch_idle_ack_ignored", ir_valid, 1'b0);
    @(negedge clk);
    chk1("refetch_valid", ir_valid, 1'b1);
    chk32("refetch_ir", ir, 32'h0800_0004);
    ack_force = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
